// File: rtl/store_buffer.sv
// MEM-stage store buffer: lane-aligns stores, queues them, drains to data memory over req/ack.
// Optional SB_LDCHECK_EN: loads stall only on a queued word-address match instead of on any non-empty queue.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          MemWrite,
   input  logic          MemRead,
   input  logic [31:0]   Address,
   input  logic [31:0]   RTOut,
   input  logic [1:0]    Ssel,
   input  logic          Flush,
   output logic          Stall,
   output logic          AddrErr,
   output logic          FlushDone,
   output logic          DmReq,
   output logic [31:0]   DmAddr,
   output logic [31:0]   DmData,
   output logic [3:0]    DmBe,
   input  logic          DmAck,
   output logic          Empty,
   output logic [CW-1:0] Count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   logic [29:0]   q_addr [DEPTH];
   logic [31:0]   q_data [DEPTH];
   logic [3:0]    q_be   [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] cnt;
   logic [0:0]    state;
   logic          addr_err;
   logic          flush_done;

   logic          aligned;
   logic [31:0]   lane_data;
   logic [3:0]    lane_be;
   logic          empty;
   logic          full;
   logic          ld_hazard;
   logic          stall;
   logic          push;
   logic          pop;

   always_comb begin
      aligned   = 1'b1;
      lane_data = RTOut;
      lane_be   = 4'b1111;
      case (Ssel)
         2'b10: begin
            lane_data = {24'd0, RTOut[7:0]} << {Address[1:0], 3'b000};
            lane_be   = 4'b0001 << Address[1:0];
         end
         2'b01: begin
            aligned   = ~Address[0];
            lane_data = {16'd0, RTOut[15:0]} << {Address[1], 4'b0000};
            lane_be   = 4'b0011 << {Address[1], 1'b0};
         end
         default: aligned = (Address[1:0] == 2'b00);
      endcase
   end

   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));

`ifdef SB_LDCHECK_EN
   logic hit;

   // An entry is live when its distance from head is below the occupancy.
   always_comb begin
      logic [PW-1:0] offs;
      offs = '0;
      hit  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = PW'(i) - head;
         if ((CW'(offs) < cnt) && (q_addr[i] == Address[31:2])) hit = 1'b1;
      end
   end

   assign ld_hazard = MemRead & ~MemWrite & hit;
`else
   assign ld_hazard = MemRead & ~MemWrite & ~empty;
`endif

   // A same-cycle pop never frees the slot for a stalled store; keeps DmAck off the stall path.
   assign stall = (MemWrite & full) | ld_hazard | (state == ST_FLUSH) | Flush;
   assign push  = MemWrite & aligned & ~stall;
   assign pop   = ~empty & DmAck;

   always_ff @(posedge Clk) begin
      if (push) begin
         q_addr[tail] <= Address[31:2];
         q_data[tail] <= lane_data;
         q_be[tail]   <= lane_be;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         head       <= '0;
         tail       <= '0;
         cnt        <= '0;
         state      <= ST_RUN;
         addr_err   <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         cnt        <= cnt + CW'(push) - CW'(pop);
         addr_err   <= MemWrite & ~aligned & ~stall;
         flush_done <= 1'b0;
         if (state == ST_RUN) begin
            if (Flush) state <= ST_FLUSH;
         end else if (empty) begin
            state      <= ST_RUN;
            flush_done <= 1'b1;
         end
      end
   end

   assign Stall     = stall;
   assign AddrErr   = addr_err;
   assign FlushDone = flush_done;
   assign DmReq     = ~empty;
   assign DmAddr    = empty ? 32'd0 : {q_addr[head], 2'b00};
   assign DmData    = empty ? 32'd0 : q_data[head];
   assign DmBe      = empty ? 4'd0  : q_be[head];
   assign Empty     = empty;
   assign Count     = cnt;

endmodule
